// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: queue entry layout and the canonical NOP.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Fetch queue between PC/instruction memory and decode: FWFT FIFO of {instr, pc, pc+4}
// that absorbs decode stalls and memory latency, and drives the PC register stall.
module if_fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [XLEN-1:0]          pcF_i,
    input  logic                     imem_valid_i,
    input  logic [31:0]              instrF_i,
    input  logic                     stallD_i,
    input  logic                     flushD_i,
    output logic                     stallF_o,
    output logic                     validD_o,
    output logic [31:0]              instrD_o,
    output logic [XLEN-1:0]          pcD_o,
    output logic [XLEN-1:0]          pcplus4D_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic full;
    logic pop;
    logic push;
    fetch_entry_t head;

    assign full     = (count == CW'(DEPTH));
    assign validD_o = (count != '0);
    assign pop      = validD_o & ~stallD_i;
    // A full queue still accepts a new word when the head leaves in the same cycle.
    assign stallF_o = ~flushD_i & (~imem_valid_i | (full & ~pop));
    assign push     = imem_valid_i & ~stallF_o & ~flushD_i;

    // NOTE: storage carries no reset; validity is tracked solely by count, so stale
    // entries are never observable and the array maps cleanly onto plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: instrF_i, pc: pcF_i, pcplus4: pcF_i + XLEN'(4)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flushD_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // First-word-fall-through: head is read straight from storage, masked when empty.
    assign head       = mem[rd_ptr];
    assign instrD_o   = validD_o ? head.instr   : NOP_INSTR;
    assign pcD_o      = validD_o ? head.pc      : '0;
    assign pcplus4D_o = validD_o ? head.pcplus4 : '0;
    assign count_o    = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue (DEPTH=2): hand-computed vector table for the stall/flush/latency
// corners, plus a queue scoreboard that tracks every accepted word through to decode.
module tb_if_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        imem_valid;
    logic [31:0] instr_f;
    logic        stall_d;
    logic        flush_d;
    logic        stall_f;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic [1:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .pcF_i        (pc_f),
        .imem_valid_i (imem_valid),
        .instrF_i     (instr_f),
        .stallD_i     (stall_d),
        .flushD_i     (flush_d),
        .stallF_o     (stall_f),
        .validD_o     (valid_d),
        .instrD_o     (instr_d),
        .pcD_o        (pc_d),
        .pcplus4D_o   (pcplus4_d),
        .count_o      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        stl;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_pc;
        int          e_count;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_for(input logic [31:0] pc);
        return 32'hC0DE_0000 ^ pc;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                         input logic stl, input logic fl);
        imem_valid = iv;
        pc_f       = pc;
        instr_f    = instr;
        stall_d    = stl;
        flush_d    = fl;
    endtask

    // Called at the negative edge: compare outputs against the scoreboard, then
    // apply what the upcoming edge should do to the expected queue.
    task automatic sb_cycle();
        int   n;
        logic e_valid, e_full, e_pop, e_stall, e_push;
        logic [31:0] e_instr, e_pc, e_pc4;
        n       = sb_q.size();
        e_valid = (n != 0);
        e_full  = (n == DEPTH);
        e_pop   = e_valid && !stall_d;
        e_stall = !flush_d && (!imem_valid || (e_full && !e_pop));
        e_push  = imem_valid && !e_stall && !flush_d;
        e_instr = e_valid ? sb_q[0].instr : NOP_INSTR;
        e_pc    = e_valid ? sb_q[0].pc : 32'h0;
        e_pc4   = e_valid ? sb_q[0].pc + 32'd4 : 32'h0;
        check("sb_count",   64'(count),     64'(n));
        check("sb_valid",   64'(valid_d),   64'(e_valid));
        check("sb_stallF",  64'(stall_f),   64'(e_stall));
        check("sb_instr",   64'(instr_d),   64'(e_instr));
        check("sb_pc",      64'(pc_d),      64'(e_pc));
        check("sb_pcplus4", 64'(pcplus4_d), 64'(e_pc4));
        if (flush_d) begin
            sb_q.delete();
        end else begin
            if (e_pop)  void'(sb_q.pop_front());
            if (e_push) sb_q.push_back('{instr: instr_f, pc: pc_f});
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic stl, input logic fl);
        drive(iv, pc, instr, stl, fl);
        @(negedge clk);
        sb_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected values are the pre-edge outputs for each cycle, starting from empty.
        //           iv    pc           stl   fl    stallF valid  head pc      count
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   0};
        vecs[1]  = '{1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1};
        vecs[2]  = '{1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 1};
        vecs[3]  = '{1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 1};
        vecs[4]  = '{1'b1, 32'h110, 1'b1, 1'b0, 1'b1, 1'b1, 32'h108, 2};
        vecs[5]  = '{1'b1, 32'h110, 1'b1, 1'b0, 1'b1, 1'b1, 32'h108, 2};
        vecs[6]  = '{1'b1, 32'h110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h108, 2};
        vecs[7]  = '{1'b1, 32'h114, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 2};
        vecs[8]  = '{1'b0, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   0};
        vecs[9]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   0};
        vecs[10] = '{1'b1, 32'h204, 1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1};
        vecs[11] = '{1'b0, 32'h208, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 2};
        vecs[12] = '{1'b0, 32'h208, 1'b0, 1'b0, 1'b1, 1'b1, 32'h204, 1};
        vecs[13] = '{1'b0, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   0};
        vecs[14] = '{1'b1, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   0};
        vecs[15] = '{1'b1, 32'h20C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h208, 1};
        vecs[16] = '{1'b0, 32'h210, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20C, 1};

        // Reset state, visible without any clock edge.
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        check("rst_valid",   64'(valid_d),   64'(0));
        check("rst_count",   64'(count),     64'(0));
        check("rst_instr",   64'(instr_d),   64'(32'h13));
        check("rst_pc",      64'(pc_d),      64'(0));
        check("rst_pcplus4", 64'(pcplus4_d), 64'(0));
        check("rst_stallF",  64'(stall_f),   64'(1));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Streaming, decode stall, flush and memory latency from the table.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].pc, instr_for(vecs[i].pc), vecs[i].stl, vecs[i].fl);
            @(negedge clk);
            check($sformatf("vec%0d_stallF", i), 64'(stall_f), 64'(vecs[i].e_stall));
            check($sformatf("vec%0d_valid", i),  64'(valid_d), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d_pc", i),     64'(pc_d),    64'(vecs[i].e_pc));
            check($sformatf("vec%0d_count", i),  64'(count),   64'(vecs[i].e_count));
            sb_cycle();
            @(posedge clk);
            #1;
        end

        // Drain, then PC+4 wrap at the top of the address space.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("wrap_pc",      64'(pc_d),      64'(32'hFFFF_FFFC));
        check("wrap_pcplus4", 64'(pcplus4_d), 64'(32'h0000_0000));
        check("wrap_instr",   64'(instr_d),   64'(32'h1234_5678));
        sb_cycle();
        @(posedge clk);
        #1;

        // Ten push/pop cycles so both pointers wrap several times; order is scoreboarded.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h400 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        end

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
        end

        // Fill, then assert reset between edges: queue must empty immediately.
        step(1'b1, 32'h800, 32'hD000_0800, 1'b1, 1'b0);
        step(1'b1, 32'h804, 32'hD000_0804, 1'b1, 1'b0);
        step(1'b1, 32'h808, 32'hD000_0808, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #2;
        check("pre_reset_count", 64'(count), 64'(sb_q.size()));
        reset = 1'b1;
        #1;
        check("midrst_valid",  64'(valid_d), 64'(0));
        check("midrst_count",  64'(count),   64'(0));
        check("midrst_instr",  64'(instr_d), 64'(32'h13));
        check("midrst_pc",     64'(pc_d),    64'(0));
        check("midrst_stallF", 64'(stall_f), 64'(1));
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 32'h900, 32'hE000_0900, 1'b0, 1'b0);
        step(1'b1, 32'h904, 32'hE000_0904, 1'b0, 1'b0);
        step(1'b0, 32'h908, 32'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
